md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//   Multiply/divide unit of the five-stage pipelined CPU, in the E stage beside the ALU.
//   Consumes MDOp/Start/MDWrite/MDSel from the decode controller and E-stage operands A (rs), B (rt).
//   Owns HI/LO and runs mult/multu/div/divu as multi-cycle operations.
//   Busy/Start feed the hazard unit, which stalls any mf*/mt*/md instruction in D while active.
// PARAMETERS
//   MULT_CYCLES  5   cycles Busy stays high for mult/multu
//   DIV_CYCLES   10  cycles Busy stays high for div/divu
// PORTS
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous, active-low reset (0 = reset)
//   Start    in   1   launch mult/multu/div/divu this cycle
//   MDOp     in   3   000 MTLO, 001 MTHI, 010 MULT, 011 MULTU, 100 DIV, 101 DIVU
//   MDWrite  in   1   instruction in E is an md-class op (mt*, mult*, div*)
//   MDSel    in   1   read select for MDOut: 1 = HI, 0 = LO
//   A        in   32  rs operand (forwarded)
//   B        in   32  rt operand (forwarded)
//   Busy     out  1   operation in progress
//   HI       out  32  HI register
//   LO       out  32  LO register
//   MDOut    out  32  MDSel ? HI : LO, combinational (mfhi/mflo result)
// BEHAVIOUR
//   Reset (reset==0, async): HI=0, LO=0, Busy=0, cycle counter=0, pending result regs=0.
//     A reset during an operation aborts it. HI/LO are not written.
//   Idle (Busy==0), sampled at rising edge:
//     - Start=1 with MDOp in {MULT,MULTU,DIV,DIVU}:
//       - Compute the result into pending regs pHI/pLO.
//       - Load counter with N (MULT_CYCLES or DIV_CYCLES).
//       - Busy=1 from the next cycle for exactly N cycles.
//     - MDWrite=1, Start=0, MDOp=MTLO: LO<=A at this edge. MDOp=MTHI: HI<=A. No Busy.
//     - Start=1 with MDOp MTLO/MTHI is treated as MTLO/MTHI (no Busy).
//   Busy: counter decrements each edge. On the edge where counter==1: HI<=pHI, LO<=pLO, counter<=0.
//     - Busy falls on that same edge, so the new HI/LO are visible in the first cycle Busy==0.
//     - Busy is a registered output: Busy = (counter != 0).
//   While Busy: Start and MDWrite are ignored and HI/LO hold.
//     - The hazard unit guarantees this never happens; the unit must still not corrupt state.
//   Arithmetic:
//     - MULT: {HI,LO} = signed(A)*signed(B), 64-bit.
//     - MULTU: same, unsigned.
//     - DIV: LO = A/B signed, truncated toward zero; HI = A%B, sign of dividend.
//     - DIVU: same, unsigned.
//     - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//     - Division by zero (B==0): runs the full DIV_CYCLES; HI/LO keep their prior values.
//   Operands are captured at the Start edge. A/B changes during Busy have no effect.
//   Start and MDWrite are never sampled when reset==0.
// TESTING
//   mult: A=0xFFFFFFFE(-2), B=3, Start pulse -> Busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//   multu: same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 Busy cycles.
//     MDSel=1 -> MDOut=0x00000002.
//   div: A=-7 (0xFFFFFFF9), B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     divu: A=7, B=2 -> LO=3, HI=1.
//   mtlo A=0x12345678, then mthi A=0x9ABCDEF0 on consecutive cycles -> LO/HI update at each edge.
//     Busy never asserts.
//   div with B=0 after mtlo 0x11 -> Busy 10 cycles, LO stays 0x11.
//     Start pulse mid-Busy is ignored; Busy length is unchanged.
//   reset low at Busy cycle 3 of a mult -> Busy=0 and HI=LO=0 immediately. No late write after reset releases.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// It sits in the E stage next to the ALU. Results are computed when the
// operation starts and are held in pending registers. They are committed to
// HI/LO when the busy countdown expires, which mimics a real iterative unit.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic        MDWrite,
  input  logic        MDSel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam logic [2:0] OP_MTLO  = 3'b000;
  localparam logic [2:0] OP_MTHI  = 3'b001;
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_MULTU = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;

  localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES);

  logic [7:0]  count;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        p_valid;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quo_s;
  logic [31:0]        rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;

  logic        launch;
  logic        mt_lo;
  logic        mt_hi;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_valid;
  logic [7:0]  res_cycles;

  assign prod_s = $signed(A) * $signed(B);
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Quotient/remainder, with B==0 guarded and the signed overflow case pinned
  always_comb begin
    quo_s = 32'd0;
    rem_s = 32'd0;
    quo_u = 32'd0;
    rem_u = 32'd0;
    if (B != 32'd0) begin
      quo_u = A / B;
      rem_u = A % B;
      if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
        quo_s = 32'h8000_0000;
        rem_s = 32'd0;
      end else begin
        quo_s = $signed(A) / $signed(B);
        rem_s = $signed(A) % $signed(B);
      end
    end
  end

  // Decode the E-stage request into a launch or a direct HI/LO move
  always_comb begin
    launch     = 1'b0;
    mt_lo      = 1'b0;
    mt_hi      = 1'b0;
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    res_valid  = 1'b0;
    res_cycles = 8'd0;
    case (MDOp)
      OP_MULT: begin
        launch     = Start;
        res_hi     = prod_s[63:32];
        res_lo     = prod_s[31:0];
        res_valid  = 1'b1;
        res_cycles = MULT_LOAD;
      end
      OP_MULTU: begin
        launch     = Start;
        res_hi     = prod_u[63:32];
        res_lo     = prod_u[31:0];
        res_valid  = 1'b1;
        res_cycles = MULT_LOAD;
      end
      OP_DIV: begin
        launch     = Start;
        res_hi     = rem_s;
        res_lo     = quo_s;
        res_valid  = (B != 32'd0);
        res_cycles = DIV_LOAD;
      end
      OP_DIVU: begin
        launch     = Start;
        res_hi     = rem_u;
        res_lo     = quo_u;
        res_valid  = (B != 32'd0);
        res_cycles = DIV_LOAD;
      end
      OP_MTLO: mt_lo = MDWrite | Start;
      OP_MTHI: mt_hi = MDWrite | Start;
      default: ;
    endcase
  end

  // Countdown, pending-result capture and HI/LO update; requests ignored while busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= 8'd0;
      p_hi    <= 32'd0;
      p_lo    <= 32'd0;
      p_valid <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else if (count != 8'd0) begin
      if (count == 8'd1 && p_valid) begin
        HI <= p_hi;
        LO <= p_lo;
      end
      count <= count - 8'd1;
    end else if (launch) begin
      p_hi    <= res_hi;
      p_lo    <= res_lo;
      p_valid <= res_valid;
      count   <= res_cycles;
    end else if (mt_lo) begin
      LO <= A;
    end else if (mt_hi) begin
      HI <= A;
    end
  end

  assign Busy  = (count != 8'd0);
  assign MDOut = MDSel ? HI : LO;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'b000;
  logic        MDWrite = 1'b0;
  logic        MDSel = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDOut;

  int total = 0;
  int bad = 0;

  localparam logic [2:0] MTLO  = 3'b000;
  localparam logic [2:0] MTHI  = 3'b001;
  localparam logic [2:0] MULT  = 3'b010;
  localparam logic [2:0] MULTU = 3'b011;
  localparam logic [2:0] DIV   = 3'b100;
  localparam logic [2:0] DIVU  = 3'b101;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .MDWrite(MDWrite),
    .MDSel(MDSel), .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [2:0] op, input logic wr,
                               input logic [31:0] a, input logic [31:0] b);
    Start   = st;
    MDOp    = op;
    MDWrite = wr;
    A       = a;
    B       = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBusyWindow(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, " busy"}, {31'd0, Busy}, 32'd1);
      tick();
    end
    checkOutput({tag, " busy end"}, {31'd0, Busy}, 32'd0);
  endtask

  // Directed sequence
  initial begin
    tick();
    tick();
    checkOutput("reset busy", {31'd0, Busy}, 32'd0);
    checkOutput("reset HI", HI, 32'd0);
    checkOutput("reset LO", LO, 32'd0);
    checkOutput("reset MDOut", MDOut, 32'd0);
    reset = 1'b1;
    tick();

    // signed multiply, operands scrambled after launch
    applyStimulus(1'b1, MULT, 1'b0, 32'hFFFF_FFFE, 32'd3);
    tick();
    applyStimulus(1'b0, MULT, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    checkOutput("mult HI hold", HI, 32'd0);
    checkBusyWindow("mult", 5);
    checkOutput("mult HI", HI, 32'hFFFF_FFFF);
    checkOutput("mult LO", LO, 32'hFFFF_FFFA);

    // unsigned multiply and read mux
    applyStimulus(1'b1, MULTU, 1'b0, 32'hFFFF_FFFE, 32'd3);
    tick();
    applyStimulus(1'b0, MULTU, 1'b0, 32'd0, 32'd0);
    checkBusyWindow("multu", 5);
    checkOutput("multu HI", HI, 32'h0000_0002);
    checkOutput("multu LO", LO, 32'hFFFF_FFFA);
    MDSel = 1'b1;
    #1;
    checkOutput("multu MDOut HI", MDOut, 32'h0000_0002);
    MDSel = 1'b0;
    #1;
    checkOutput("multu MDOut LO", MDOut, 32'hFFFF_FFFA);

    // signed divide: -7 / 2
    applyStimulus(1'b1, DIV, 1'b0, 32'hFFFF_FFF9, 32'd2);
    tick();
    applyStimulus(1'b0, DIV, 1'b0, 32'd100, 32'd7);
    checkBusyWindow("div", 10);
    checkOutput("div LO", LO, 32'hFFFF_FFFD);
    checkOutput("div HI", HI, 32'hFFFF_FFFF);

    // signed divide: 7 / -2
    applyStimulus(1'b1, DIV, 1'b0, 32'd7, 32'hFFFF_FFFE);
    tick();
    applyStimulus(1'b0, DIV, 1'b0, 32'd0, 32'd0);
    checkBusyWindow("div neg", 10);
    checkOutput("div neg LO", LO, 32'hFFFF_FFFD);
    checkOutput("div neg HI", HI, 32'h0000_0001);

    // unsigned divide
    applyStimulus(1'b1, DIVU, 1'b0, 32'd7, 32'd2);
    tick();
    applyStimulus(1'b0, DIVU, 1'b0, 32'd0, 32'd0);
    checkBusyWindow("divu", 10);
    checkOutput("divu LO", LO, 32'd3);
    checkOutput("divu HI", HI, 32'd1);

    // signed overflow divide
    applyStimulus(1'b1, DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    applyStimulus(1'b0, DIV, 1'b0, 32'd0, 32'd0);
    checkBusyWindow("div ovf", 10);
    checkOutput("div ovf LO", LO, 32'h8000_0000);
    checkOutput("div ovf HI", HI, 32'd0);

    // mtlo then mthi on consecutive cycles
    applyStimulus(1'b0, MTLO, 1'b1, 32'h1234_5678, 32'd0);
    tick();
    checkOutput("mtlo LO", LO, 32'h1234_5678);
    checkOutput("mtlo busy", {31'd0, Busy}, 32'd0);
    applyStimulus(1'b0, MTHI, 1'b1, 32'h9ABC_DEF0, 32'd0);
    tick();
    checkOutput("mthi HI", HI, 32'h9ABC_DEF0);
    checkOutput("mthi LO keep", LO, 32'h1234_5678);
    checkOutput("mthi busy", {31'd0, Busy}, 32'd0);

    // Start with MTLO behaves as mtlo
    applyStimulus(1'b1, MTLO, 1'b0, 32'h0000_0055, 32'd0);
    tick();
    checkOutput("start mtlo LO", LO, 32'h0000_0055);
    checkOutput("start mtlo busy", {31'd0, Busy}, 32'd0);

    // MDWrite with a non-move op and no Start does nothing
    applyStimulus(1'b0, MULT, 1'b1, 32'h0000_0077, 32'd2);
    tick();
    checkOutput("idle mult LO", LO, 32'h0000_0055);
    checkOutput("idle mult busy", {31'd0, Busy}, 32'd0);

    // divide by zero after mtlo 0x11, with requests injected mid-busy
    applyStimulus(1'b0, MTLO, 1'b1, 32'h0000_0011, 32'd0);
    tick();
    checkOutput("mtlo 11", LO, 32'h0000_0011);
    applyStimulus(1'b1, DIV, 1'b0, 32'h0000_0123, 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      checkOutput("div0 busy", {31'd0, Busy}, 32'd1);
      if (i == 2) applyStimulus(1'b1, MULT, 1'b0, 32'd5, 32'd5);
      else if (i == 4) applyStimulus(1'b0, MTLO, 1'b1, 32'hDEAD_0000, 32'd0);
      else applyStimulus(1'b0, DIV, 1'b0, 32'd0, 32'd0);
      tick();
    end
    checkOutput("div0 busy end", {31'd0, Busy}, 32'd0);
    checkOutput("div0 LO", LO, 32'h0000_0011);
    checkOutput("div0 HI", HI, 32'h9ABC_DEF0);
    tick();
    checkOutput("div0 no restart", {31'd0, Busy}, 32'd0);

    // reset in the third busy cycle of a mult
    applyStimulus(1'b1, MULT, 1'b0, 32'hFFFF_FFFE, 32'd3);
    tick();
    applyStimulus(1'b0, MULT, 1'b0, 32'd0, 32'd0);
    checkOutput("rst mult busy1", {31'd0, Busy}, 32'd1);
    tick();
    checkOutput("rst mult busy2", {31'd0, Busy}, 32'd1);
    tick();
    checkOutput("rst mult busy3", {31'd0, Busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async rst busy", {31'd0, Busy}, 32'd0);
    checkOutput("async rst HI", HI, 32'd0);
    checkOutput("async rst LO", LO, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("post rst busy", {31'd0, Busy}, 32'd0);
    checkOutput("post rst HI", HI, 32'd0);
    checkOutput("post rst LO", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
